// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder.
// Holds the opcode constants the encoder understands, the encoder FSM state
// type, and the signed immediate field widths for each instruction format.
package imm_encoder_pkg;

    // Opcode constants
    localparam logic [6:0] ADDI    = 7'b0010011;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] LD      = 7'b0000011;
    localparam logic [6:0] TYPE_S  = 7'b0100011;
    localparam logic [6:0] TYPE_SB = 7'b1100011;
    localparam logic [6:0] TYPE_U  = 7'b0110111;
    localparam logic [6:0] TYPE_UJ = 7'b1101111;

    // Upper-immediate load used as the first word of a wide ADDI expansion
    localparam logic [6:0] OPC_LUI = TYPE_U;

    // Signed immediate widths per format
    localparam int unsigned IMM_W_I = 12;
    localparam int unsigned IMM_W_S = 7;
    localparam int unsigned IMM_W_U = 20;

    // IDLE: no word held; OUT: final word held; HI: LUI held, ADDI pending
    typedef enum logic [1:0] {
        IDLE,
        OUT,
        HI
    } immenc_state_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational instruction packer.
// Scatters the immediate into the 32-bit word for the format selected by the
// opcode and reports whether the immediate fits that format's signed range.
// Ports:
//   opcode, rd, rs1, rs2, funct3  instruction fields
//   imm      XLEN-bit signed immediate
//   instr    packed instruction word
//   fits     imm equals sign-extension of the format's low N bits
//   known    opcode is one of the supported formats
module imm_encoder_pack
    import imm_encoder_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm,
    output logic [31:0]     instr,
    output logic            fits,
    output logic            known
);

    logic fit_i;
    logic fit_s;
    logic fit_u;

    assign fit_i = (imm == {{(XLEN-IMM_W_I){imm[IMM_W_I-1]}}, imm[IMM_W_I-1:0]});
    assign fit_s = (imm == {{(XLEN-IMM_W_S){imm[IMM_W_S-1]}}, imm[IMM_W_S-1:0]});
    assign fit_u = (imm == {{(XLEN-IMM_W_U){imm[IMM_W_U-1]}}, imm[IMM_W_U-1:0]});

    always_comb begin
        instr = '0;
        fits  = 1'b0;
        known = 1'b0;
        case (opcode)
            ADDI, JALR, LD: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                fits  = fit_i;
                known = 1'b1;
            end
            TYPE_S: begin
                instr = {imm[6:0], rs2, rs1, funct3, 5'b00000, opcode};
                fits  = fit_s;
                known = 1'b1;
            end
            TYPE_SB: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                fits  = fit_i;
                known = 1'b1;
            end
            TYPE_U: begin
                instr = {imm[19:0], rd, opcode};
                fits  = fit_u;
                known = 1'b1;
            end
            TYPE_UJ: begin
                instr = {imm[19], imm[8:0], imm[9], imm[18:10], rd, opcode};
                fits  = fit_u;
                known = 1'b1;
            end
            default: begin
                instr = '0;
                fits  = 1'b0;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate/instruction encoder.
// Accepts an opcode, register fields and a signed immediate and emits the
// encoded 32-bit instruction one cycle later. Wide ADDI immediates are split
// into a LUI+ADDI pair when EXPAND_EN is set; unencodable requests are consumed
// and reported with a one-cycle o_err pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready   request handshake
//   i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_imm   request fields
//   o_valid / i_ready   output word handshake
//   o_instr             encoded word (registered)
//   o_last              word is the final one of its request
//   o_err               accepted request was unencodable
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter bit          EXPAND_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic            o_last,
    output logic            o_err
);

    // Expansion range: hi20 must not wrap when lo12 is rounded up
    localparam logic signed [XLEN-1:0] EXP_MIN = -(XLEN'(1) << 31);
    localparam logic signed [XLEN-1:0] EXP_MAX = (XLEN'(1) << 31) - XLEN'(2049);

    immenc_state_t state;
    immenc_state_t state_nxt;

    logic [31:0]     a_instr;
    logic            a_fits;
    logic            a_known;

    logic [6:0]      b_opcode;
    logic [4:0]      b_rd;
    logic [4:0]      b_rs1;
    logic [XLEN-1:0] b_imm;
    logic [31:0]     b_instr;
    logic            b_fits;
    logic            b_known;

    logic [4:0]      pend_rd;
    logic [11:0]     pend_lo;
    logic [19:0]     hi20;

    logic            in_exp_range;
    logic            req_expand;
    logic            req_err;
    logic            accept;

    // Packs the request exactly as presented
    imm_encoder_pack #(.XLEN(XLEN)) u_pack_req (
        .opcode (i_opcode),
        .rd     (i_rd),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .funct3 (i_funct3),
        .imm    (i_imm),
        .instr  (a_instr),
        .fits   (a_fits),
        .known  (a_known)
    );

    // Expansion words: LUI from the live request while accepting, the stored
    // ADDI while in HI. Only the 17 bits of the ADDI half need holding.
    always_comb begin
        if (state == HI) begin
            b_opcode = ADDI;
            b_rd     = pend_rd;
            b_rs1    = pend_rd;
            b_imm    = {{(XLEN-12){pend_lo[11]}}, pend_lo};
        end else begin
            b_opcode = OPC_LUI;
            b_rd     = i_rd;
            b_rs1    = '0;
            b_imm    = {{(XLEN-20){hi20[19]}}, hi20};
        end
    end

    imm_encoder_pack #(.XLEN(XLEN)) u_pack_exp (
        .opcode (b_opcode),
        .rd     (b_rd),
        .rs1    (b_rs1),
        .rs2    (5'd0),
        .funct3 (3'd0),
        .imm    (b_imm),
        .instr  (b_instr),
        .fits   (b_fits),
        .known  (b_known)
    );

    // (imm + 2048)[31:12]: adding 2048 carries into bit 12 exactly when imm[11]
    // is set, and lo12 = imm - (hi20 << 12) reduces to imm[11:0].
    assign hi20 = i_imm[31:12] + {19'd0, i_imm[11]};

    assign in_exp_range = ($signed(i_imm) >= EXP_MIN) && ($signed(i_imm) <= EXP_MAX);

    assign req_expand = EXPAND_EN && (i_opcode == ADDI) && !a_fits && in_exp_range
                        && b_fits && b_known;
    assign req_err    = !a_known || (!a_fits && !req_expand);
    assign accept     = i_valid && o_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, OUT: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = IDLE;
                    end else if (req_expand) begin
                        state_nxt = HI;
                    end else begin
                        state_nxt = OUT;
                    end
                end else if ((state == OUT) && i_ready) begin
                    state_nxt = IDLE;
                end
            end
            HI: begin
                if (i_ready) begin
                    state_nxt = OUT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
            end
            OUT: begin
                o_valid = 1'b1;
                o_ready = i_ready;
            end
            HI: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b0;
            end
        endcase
    end

    // Output word register; only moves on accept or on leaving HI, so the
    // word holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_instr <= '0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
            pend_rd <= '0;
            pend_lo <= '0;
        end else begin
            o_err <= accept && req_err;
            if (state == HI) begin
                if (i_ready) begin
                    o_instr <= b_instr;
                    o_last  <= 1'b1;
                end
            end else if (accept && !req_err) begin
                if (req_expand) begin
                    o_instr <= b_instr;
                    o_last  <= 1'b0;
                    pend_rd <= i_rd;
                    pend_lo <= i_imm[11:0];
                end else begin
                    o_instr <= a_instr;
                    o_last  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases followed by randomized
// traffic scored against a behavioural encoder model and an output word queue.
module tb_imm_encoder;

    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_S    = 7'h23;
    localparam logic [6:0] OP_SB   = 7'h63;
    localparam logic [6:0] OP_U    = 7'h37;
    localparam logic [6:0] OP_UJ   = 7'h6F;

    localparam logic [6:0] OPS [7] = '{OP_ADDI, OP_JALR, OP_LD, OP_S, OP_SB, OP_U, OP_UJ};

    localparam int NB = 16;
    localparam longint BOUNDS [NB] = '{
        64'sd2047, -64'sd2048, 64'sd2048, -64'sd2049,
        64'sd63, 64'sd64, -64'sd64, -64'sd65,
        64'sd524287, -64'sd524288, 64'sd524288, -64'sd524289,
        64'sd2147481599, 64'sd2147481600, -64'sd2147483648, -64'sd2147483649
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [63:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic        o_last;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w;
        bit          last;
    } wd_t;

    wd_t q[$];
    bit  exp_err = 1'b0;

    always #5 clk = ~clk;

    imm_encoder #(.XLEN(64), .EXPAND_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_opcode (i_opcode),
        .i_rd     (i_rd),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .i_imm    (i_imm),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_instr  (o_instr),
        .o_last   (o_last),
        .o_err    (o_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fits(input longint v, input int n);
        longint lim;
        lim = 64'sd1 <<< (n - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    // Behavioural encoder: field arithmetic straight from the format rules
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input longint imm,
                                       output bit err, output bit two,
                                       output logic [31:0] w0, output logic [31:0] w1);
        longint ld, l1, l2, lf, lo_op, w, hi, lo;
        ld = longint'(rd);
        l1 = longint'(rs1);
        l2 = longint'(rs2);
        lf = longint'(f3);
        lo_op = longint'(op);
        w = 0;
        err = 1'b0;
        two = 1'b0;
        w0 = '0;
        w1 = '0;
        case (op)
            OP_ADDI, OP_JALR, OP_LD: begin
                if (fits(imm, 12)) begin
                    w = ((imm & 64'hFFF) << 20) | (l1 << 15) | (lf << 12) | (ld << 7) | lo_op;
                end else if (op == OP_ADDI && imm >= -(64'sd1 <<< 31)
                             && imm <= (64'sd1 <<< 31) - 64'sd2049) begin
                    hi = ((imm + 64'sd2048) >> 12) & 64'hFFFFF;
                    lo = (imm - (hi << 12)) & 64'hFFF;
                    two = 1'b1;
                    w = (hi << 12) | (ld << 7) | 64'h37;
                    w1 = 32'((lo << 20) | (ld << 15) | (ld << 7) | 64'h13);
                end else begin
                    err = 1'b1;
                end
            end
            OP_S: begin
                if (fits(imm, 7)) w = ((imm & 64'h7F) << 25) | (l2 << 20) | (l1 << 15) | (lf << 12) | lo_op;
                else err = 1'b1;
            end
            OP_SB: begin
                if (fits(imm, 12))
                    w = (((imm >> 5) & 64'h7F) << 25) | (l2 << 20) | (l1 << 15) | (lf << 12)
                        | ((imm & 64'h1F) << 7) | lo_op;
                else err = 1'b1;
            end
            OP_U: begin
                if (fits(imm, 20)) w = ((imm & 64'hFFFFF) << 12) | (ld << 7) | lo_op;
                else err = 1'b1;
            end
            OP_UJ: begin
                if (fits(imm, 20))
                    w = (((imm >> 19) & 64'h1) << 31) | ((imm & 64'h1FF) << 22)
                        | (((imm >> 9) & 64'h1) << 21) | (((imm >> 10) & 64'h1FF) << 12)
                        | (ld << 7) | lo_op;
                else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        w0 = 32'(w);
    endfunction

    // Scoreboard: outputs compared on every falling edge against the word queue
    always @(negedge clk) begin : scoreboard
        bit          erdy;
        bit          err;
        bit          two;
        logic [31:0] w0;
        logic [31:0] w1;
        if (!rst_n) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            erdy = 1'b1;
            if (q.size() != 0) erdy = i_ready && q[0].last;
            check("o_valid", 64'(o_valid), 64'(q.size() != 0));
            check("o_ready", 64'(o_ready), 64'(erdy));
            check("o_err", 64'(o_err), 64'(exp_err));
            if (q.size() != 0) begin
                check("o_instr", 64'(o_instr), 64'(q[0].w));
                check("o_last", 64'(o_last), 64'(q[0].last));
            end
            exp_err = 1'b0;
            if (q.size() != 0 && i_ready) void'(q.pop_front());
            if (i_valid && erdy) begin
                ref_encode(i_opcode, i_rd, i_rs1, i_rs2, i_funct3, $signed(i_imm), err, two, w0, w1);
                if (err) begin
                    exp_err = 1'b1;
                end else if (two) begin
                    q.push_back(wd_t'{w: w0, last: 1'b0});
                    q.push_back(wd_t'{w: w1, last: 1'b1});
                end else begin
                    q.push_back(wd_t'{w: w0, last: 1'b1});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
        i_valid  = 1'b1;
        i_opcode = op;
        i_rd     = rd;
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_funct3 = f3;
        i_imm    = imm;
    endtask

    initial begin : main
        logic [63:0] rv;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_opcode = '0;
        i_rd     = '0;
        i_rs1    = '0;
        i_rs2    = '0;
        i_funct3 = '0;
        i_imm    = '0;

        #12;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_instr", 64'(o_instr), 64'd0);
        check("rst_o_last", 64'(o_last), 64'd0);
        check("rst_o_err", 64'(o_err), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // ADDI rd=5, imm=-1
        req(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'd0, -64'sd1);
        step();
        i_valid = 1'b0;
        check("t1_instr", 64'(o_instr), 64'hFFF00293);
        check("t1_last", 64'(o_last), 64'd1);
        check("t1_err", 64'(o_err), 64'd0);
        step();

        // Wide ADDI expansion
        req(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 64'h12345678);
        step();
        i_valid = 1'b0;
        check("t2_lui", 64'(o_instr), 64'h123450B7);
        check("t2_lui_last", 64'(o_last), 64'd0);
        check("t2_hi_ready", 64'(o_ready), 64'd0);
        step();
        check("t2_addi", 64'(o_instr), 64'h67808093);
        check("t2_addi_last", 64'(o_last), 64'd1);
        step();

        // Rounding boundary and out-of-range ADDI
        req(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 64'h800);
        step();
        i_valid = 1'b0;
        check("t3_lui", 64'(o_instr), 64'h000010B7);
        step();
        check("t3_addi", 64'(o_instr), 64'h80008093);
        step();
        req(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 64'h7FFFFFFF);
        step();
        i_valid = 1'b0;
        check("t3_err", 64'(o_err), 64'd1);
        check("t3_err_valid", 64'(o_valid), 64'd0);
        step();
        check("t3_err_pulse", 64'(o_err), 64'd0);

        // SB with back-pressure
        req(OP_SB, 5'd0, 5'd2, 5'd3, 3'd0, -64'sd4);
        i_ready = 1'b0;
        step();
        i_valid = 1'b0;
        repeat (3) begin
            check("t4_hold", 64'(o_instr), 64'hFE310E63);
            check("t4_ready", 64'(o_ready), 64'd0);
            step();
        end
        i_ready = 1'b1;
        req(OP_ADDI, 5'd2, 5'd0, 5'd0, 3'd0, 64'd5);
        #1;
        check("t4_release_ready", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        check("t4_next", 64'(o_instr), 64'h00500113);
        step();

        // UJ scatter and overflow
        req(OP_UJ, 5'd1, 5'd0, 5'd0, 3'd0, 64'h201);
        step();
        i_valid = 1'b0;
        check("t5_uj", 64'(o_instr), 64'h006000EF);
        step();
        req(OP_UJ, 5'd1, 5'd0, 5'd0, 3'd0, 64'h80000);
        step();
        i_valid = 1'b0;
        check("t5_err", 64'(o_err), 64'd1);
        check("t5_err_valid", 64'(o_valid), 64'd0);
        step();

        // Reset while the LUI is held
        req(OP_ADDI, 5'd3, 5'd0, 5'd0, 3'd0, 64'h12345678);
        i_ready = 1'b0;
        step();
        i_valid = 1'b0;
        check("t6_in_hi", 64'(o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(o_valid), 64'd0);
        check("t6_rst_ready", 64'(o_ready), 64'd1);
        step();
        rst_n = 1'b1;
        i_ready = 1'b1;
        step();
        step();
        check("t6_no_addi", 64'(o_valid), 64'd0);
        check("t6_ready", 64'(o_ready), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_valid  = ($urandom_range(0, 9) < 7);
            i_ready  = ($urandom_range(0, 3) != 0);
            i_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 6)];
            i_rd     = 5'($urandom);
            i_rs1    = 5'($urandom);
            i_rs2    = 5'($urandom);
            i_funct3 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                i_imm = BOUNDS[$urandom_range(0, NB - 1)];
            end else begin
                rv = {$urandom, $urandom};
                i_imm = 64'($signed(rv) >>> $urandom_range(0, 63));
            end
            step();
        end

        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
